// File: rtl/game_pkg.sv
// Shared encodings and mm:ss BCD helpers for the game phase controller and its countdown.
package game_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned TIME_W  = 4 * DIGIT_W;
  localparam int unsigned SECS_W  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  function automatic logic bcd_is_zero(input logic [TIME_W-1:0] t);
    return t == '0;
  endfunction

  function automatic logic [SECS_W-1:0] bcd_to_secs(input logic [TIME_W-1:0] t);
    return SECS_W'(t[15:12]) * SECS_W'(600) + SECS_W'(t[11:8]) * SECS_W'(60)
         + SECS_W'(t[7:4]) * SECS_W'(10) + SECS_W'(t[3:0]);
  endfunction

  function automatic logic [TIME_W-1:0] secs_to_bcd(input logic [SECS_W-1:0] s);
    logic [SECS_W-1:0] m;
    logic [SECS_W-1:0] r;
    m = s / SECS_W'(60);
    r = s % SECS_W'(60);
    return {DIGIT_W'(m / SECS_W'(10)), DIGIT_W'(m % SECS_W'(10)),
            DIGIT_W'(r / SECS_W'(10)), DIGIT_W'(r % SECS_W'(10))};
  endfunction

endpackage

// File: rtl/bcd_countdown.sv
// mm:ss BCD countdown register: load to start value or saturating decrement by N seconds.
module bcd_countdown
  import game_pkg::*;
#(
  parameter logic [15:0] START_BCD = 16'h0500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              dec_en,
  input  logic [SECS_W-1:0] dec_amt,
  output logic [15:0]       time_bcd,
  output logic              zero_next_c
);

  logic [TIME_W-1:0] time_q, time_d;
  logic [SECS_W-1:0] secs_now;
  logic [SECS_W-1:0] secs_left;

  // Borrow chain done in binary seconds so any step size saturates cleanly at 00:00.
  always_comb begin
    secs_now  = bcd_to_secs(time_q);
    secs_left = (secs_now > dec_amt) ? secs_now - dec_amt : '0;
    time_d    = time_q;
    if (load)        time_d = START_BCD;
    else if (dec_en) time_d = secs_to_bcd(secs_left);
    zero_next_c = bcd_is_zero(time_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) time_q <= START_BCD;
    else     time_q <= time_d;
  end

  assign time_bcd = time_q;

endmodule

// File: rtl/game_phase_controller.sv
// Phase sequencer with stability counter and mm:ss countdown.
// Optional: define TIME_PENALTY_EN to also remove PENALTY_SEC from the timer per fail.
module game_phase_controller
  import game_pkg::*;
#(
  parameter int unsigned NUM_PHASES    = 4,
  parameter int unsigned MAX_STABILITY = 9,
  parameter int unsigned START_MIN     = 5,
  parameter int unsigned START_SEC     = 0,
  parameter int unsigned TICK_DIV      = 50_000_000,
  parameter int unsigned LOW_STAB      = 3,
  parameter int unsigned PENALTY_SEC   = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [NUM_PHASES-1:0]               phase_clear,
  input  logic [NUM_PHASES-1:0]               phase_fail,
  input  logic                                event_fail,
  output logic [1:0]                          state,
  output logic [$clog2(NUM_PHASES+1)-1:0]     phase_idx,
  output logic [NUM_PHASES-1:0]               phase_en,
  output logic [3:0]                          stability,
  output logic [15:0]                         time_bcd,
  output logic                                time_out,
  output logic                                game_clear,
  output logic                                game_over
);

  localparam int unsigned PIDX_W    = $clog2(NUM_PHASES + 1);
  localparam int unsigned PRE_W     = $clog2(TICK_DIV + 1);
  localparam int unsigned TICK_FAST = (TICK_DIV / 2 > 0) ? TICK_DIV / 2 : 1;
  localparam logic [TIME_W-1:0] START_BCD = secs_to_bcd(SECS_W'(START_MIN * 60 + START_SEC));
`ifdef TIME_PENALTY_EN
  localparam bit PEN_EN = 1'b1;
`else
  localparam bit PEN_EN = 1'b0;
`endif
  localparam int unsigned PEN_STEP = PEN_EN ? PENALTY_SEC : 0;

  state_e              state_q, state_d;
  logic [PIDX_W-1:0]   pidx_q, pidx_d;
  logic [NUM_PHASES-1:0] pen_q, pen_d;
  logic [3:0]          stab_q, stab_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic                time_out_q, time_out_d;
  logic                clear_q, clear_d;
  logic                over_q, over_d;

  logic                clear_hit, fail_hit, tick;
  logic [1:0]          n_fail;
  logic [PRE_W-1:0]    limit;
  logic                t_load, t_dec, t_zero_next;
  logic [SECS_W-1:0]   t_amt;

  // Inputs masked to the active phase, tick generation and timer command.
  always_comb begin
    clear_hit = |(phase_clear & pen_q);
    fail_hit  = |(phase_fail & pen_q);
    n_fail    = {1'b0, fail_hit} + {1'b0, event_fail};
    limit     = (stab_q <= 4'(LOW_STAB)) ? PRE_W'(TICK_FAST) : PRE_W'(TICK_DIV);
    tick      = (state_q == ST_PLAY) && (presc_q >= limit - PRE_W'(1));
    t_load    = start && (state_q != ST_PLAY);
    t_amt     = '0;
    if (state_q == ST_PLAY) t_amt = SECS_W'(tick) + SECS_W'(PEN_STEP) * SECS_W'(n_fail);
    t_dec     = (t_amt != '0);
  end

  bcd_countdown #(
    .START_BCD (START_BCD)
  ) u_countdown (
    .clk         (clk),
    .rst         (rst),
    .load        (t_load),
    .dec_en      (t_dec),
    .dec_amt     (t_amt),
    .time_bcd    (time_bcd),
    .zero_next_c (t_zero_next)
  );

  always_comb begin
    state_d    = state_q;
    pidx_d     = pidx_q;
    stab_d     = stab_q;
    presc_d    = presc_q;
    time_out_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PLAY;
          pidx_d  = PIDX_W'(1);
          stab_d  = 4'(MAX_STABILITY);
          presc_d = '0;
        end
      end
      ST_PLAY: begin
        presc_d = tick ? '0 : presc_q + PRE_W'(1);
        stab_d  = (stab_q > 4'(n_fail)) ? stab_q - 4'(n_fail) : 4'd0;
        // Winner order: last-phase clear, then stability exhausted, then time-out.
        if (clear_hit && pidx_q == PIDX_W'(NUM_PHASES)) begin
          state_d = ST_CLEAR;
          pidx_d  = '0;
        end else if (n_fail != 2'd0 && stab_d == 4'd0) begin
          state_d = ST_OVER;
          pidx_d  = '0;
        end else if (t_dec && t_zero_next) begin
          state_d    = ST_OVER;
          pidx_d     = '0;
          time_out_d = 1'b1;
        end else if (clear_hit) begin
          pidx_d = pidx_q + PIDX_W'(1);
        end
      end
      default: begin
        if (start) begin
          state_d = ST_IDLE;
          stab_d  = 4'(MAX_STABILITY);
          presc_d = '0;
        end
      end
    endcase
    for (int i = 0; i < NUM_PHASES; i++) pen_d[i] = (pidx_d == PIDX_W'(i + 1));
    clear_d = (state_d == ST_CLEAR);
    over_d  = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pidx_q     <= '0;
      pen_q      <= '0;
      stab_q     <= 4'(MAX_STABILITY);
      presc_q    <= '0;
      time_out_q <= 1'b0;
      clear_q    <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pidx_q     <= pidx_d;
      pen_q      <= pen_d;
      stab_q     <= stab_d;
      presc_q    <= presc_d;
      time_out_q <= time_out_d;
      clear_q    <= clear_d;
      over_q     <= over_d;
    end
  end

  assign state      = state_q;
  assign phase_idx  = pidx_q;
  assign phase_en   = pen_q;
  assign stability  = stab_q;
  assign time_out   = time_out_q;
  assign game_clear = clear_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_game_phase_controller.sv
// Directed bench: four configurations of game_phase_controller sharing stimulus.
module tb_game_phase_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] phase_clear;
  logic [3:0] phase_fail;
  logic       event_fail;

  logic [1:0]  st   [4];
  logic [2:0]  pidx [4];
  logic [3:0]  pen  [4];
  logic [3:0]  stab [4];
  logic [15:0] tbcd [4];
  logic        tout [4];
  logic        gclr [4];
  logic        gov  [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // 0: defaults; 1: 00:02 fast tick; 2: 01:00 low stability; 3: 00:05 penalty
  game_phase_controller u0 (
    .clk(clk), .rst(rst), .start(start), .phase_clear(phase_clear), .phase_fail(phase_fail),
    .event_fail(event_fail), .state(st[0]), .phase_idx(pidx[0]), .phase_en(pen[0]),
    .stability(stab[0]), .time_bcd(tbcd[0]), .time_out(tout[0]), .game_clear(gclr[0]),
    .game_over(gov[0]));

  game_phase_controller #(.START_MIN(0), .START_SEC(2), .TICK_DIV(4)) u1 (
    .clk(clk), .rst(rst), .start(start), .phase_clear(phase_clear), .phase_fail(phase_fail),
    .event_fail(event_fail), .state(st[1]), .phase_idx(pidx[1]), .phase_en(pen[1]),
    .stability(stab[1]), .time_bcd(tbcd[1]), .time_out(tout[1]), .game_clear(gclr[1]),
    .game_over(gov[1]));

  game_phase_controller #(.MAX_STABILITY(3), .START_MIN(1), .START_SEC(0), .TICK_DIV(4)) u2 (
    .clk(clk), .rst(rst), .start(start), .phase_clear(phase_clear), .phase_fail(phase_fail),
    .event_fail(event_fail), .state(st[2]), .phase_idx(pidx[2]), .phase_en(pen[2]),
    .stability(stab[2]), .time_bcd(tbcd[2]), .time_out(tout[2]), .game_clear(gclr[2]),
    .game_over(gov[2]));

  game_phase_controller #(.START_MIN(0), .START_SEC(5), .TICK_DIV(1000), .PENALTY_SEC(10)) u3 (
    .clk(clk), .rst(rst), .start(start), .phase_clear(phase_clear), .phase_fail(phase_fail),
    .event_fail(event_fail), .state(st[3]), .phase_idx(pidx[3]), .phase_en(pen[3]),
    .stability(stab[3]), .time_bcd(tbcd[3]), .time_out(tout[3]), .game_clear(gclr[3]),
    .game_over(gov[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; phase_clear = '0; phase_fail = '0; event_fail = 1'b0;
    repeat (2) step();
    check("rst_state", 32'(st[0]), 32'd0);
    check("rst_pidx", 32'(pidx[0]), 32'd0);
    check("rst_pen", 32'(pen[0]), 32'd0);
    check("rst_stab", 32'(stab[0]), 32'd9);
    check("rst_time", 32'(tbcd[0]), 32'h0500);
    check("rst_tout", 32'(tout[0]), 32'd0);
    check("rst_over", 32'(gov[0]), 32'd0);
    rst = 1'b0;
    step();

    // Phase sequencing to CLEAR
    pulse_start();
    check("go_state", 32'(st[0]), 32'd1);
    check("go_pidx", 32'(pidx[0]), 32'd1);
    check("go_pen", 32'(pen[0]), 32'h1);
    check("go_stab", 32'(stab[0]), 32'd9);
    check("go_time", 32'(tbcd[0]), 32'h0500);
    phase_clear = 4'b0010; step(); phase_clear = '0;
    check("mask_clear", 32'(pidx[0]), 32'd1);
    pulse_start();
    check("start_in_play", 32'(st[0]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      phase_clear = 4'b0001 << i; step(); phase_clear = '0;
      check("adv_pidx", 32'(pidx[0]), 32'(i + 2));
      check("adv_pen", 32'(pen[0]), 32'(4'b0010 << i));
    end
    phase_clear = 4'b1000; step(); phase_clear = '0;
    check("clr_state", 32'(st[0]), 32'd2);
    check("clr_flag", 32'(gclr[0]), 32'd1);
    check("clr_pidx", 32'(pidx[0]), 32'd0);
    check("clr_pen", 32'(pen[0]), 32'd0);
    pulse_start();
    check("clr_to_idle", 32'(st[0]), 32'd0);
    check("idle_flag", 32'(gclr[0]), 32'd0);

    // Stability drain to OVER
    pulse_start();
    check("replay", 32'(st[0]), 32'd1);
    phase_fail = 4'b0100; step(); phase_fail = '0;
    check("mask_fail", 32'(stab[0]), 32'd9);
    phase_fail = 4'b0001; event_fail = 1'b1; step(); phase_fail = '0; event_fail = 1'b0;
    check("double_fail", 32'(stab[0]), 32'd7);
    for (int i = 0; i < 6; i++) begin
      event_fail = 1'b1; step(); event_fail = 1'b0;
      check("drain_stab", 32'(stab[0]), 32'(6 - i));
    end
    check("drain_play", 32'(st[0]), 32'd1);
    event_fail = 1'b1; step(); event_fail = 1'b0;
    check("zero_stab", 32'(stab[0]), 32'd0);
    check("zero_state", 32'(st[0]), 32'd3);
    check("zero_over", 32'(gov[0]), 32'd1);
    check("zero_tout", 32'(tout[0]), 32'd0);

    // Countdown 00:02 with TICK_DIV=4
    do_reset();
    pulse_start();
    check("t_load", 32'(tbcd[1]), 32'h0002);
    repeat (3) step();
    check("t_hold", 32'(tbcd[1]), 32'h0002);
    step();
    check("t_one", 32'(tbcd[1]), 32'h0001);
    repeat (3) step();
    check("t_hold2", 32'(tbcd[1]), 32'h0001);
    step();
    check("t_zero", 32'(tbcd[1]), 32'h0000);
    check("t_pulse", 32'(tout[1]), 32'd1);
    check("t_over", 32'(st[1]), 32'd3);
    step();
    check("t_pulse_end", 32'(tout[1]), 32'd0);
    check("t_sat", 32'(tbcd[1]), 32'h0000);

    // Double-rate tick at low stability, minute borrow
    do_reset();
    pulse_start();
    check("f_stab", 32'(stab[2]), 32'd3);
    step();
    check("f_hold", 32'(tbcd[2]), 32'h0100);
    step();
    check("f_borrow", 32'(tbcd[2]), 32'h0059);
    repeat (2) step();
    check("f_next", 32'(tbcd[2]), 32'h0058);

    // Time penalty
    do_reset();
    pulse_start();
    event_fail = 1'b1; step(); event_fail = 1'b0;
    check("p_stab", 32'(stab[3]), 32'd8);
`ifdef TIME_PENALTY_EN
    check("p_time", 32'(tbcd[3]), 32'h0000);
    check("p_tout", 32'(tout[3]), 32'd1);
    check("p_state", 32'(st[3]), 32'd3);
`else
    check("p_time", 32'(tbcd[3]), 32'h0005);
    check("p_tout", 32'(tout[3]), 32'd0);
    check("p_state", 32'(st[3]), 32'd1);
`endif

    // Asynchronous reset mid-game
    rst = 1'b1; #2;
    check("async_rst", 32'(st[3]), 32'd0);
    check("async_time", 32'(tbcd[3]), 32'h0005);
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
